// File: rtl/cond_exec_unit.sv
// Conditional-execution unit: ARM condition evaluation against per-context
// flag sets, flag write-back, and an IT-style predicated-block sequencer.
module cond_exec_unit #(
  parameter int unsigned NUM_CTX = 2,
  parameter int unsigned IT_MAX  = 4,
  localparam int unsigned CW     = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [CW-1:0]     ctx_sel,
  input  logic [3:0]        cond,
  input  logic [3:0]        alu_flags,
  input  logic [1:0]        flag_write,
  input  logic              it_start,
  input  logic [3:0]        it_len,
  input  logic [IT_MAX-1:0] it_mask,
  output logic              exec,
  output logic [3:0]        flags_out,
  output logic              it_active,
  output logic [3:0]        it_remaining,
  output logic              it_error
);

  localparam int unsigned FW = 4;  // flag vector {Z,N,C,V}
  localparam int unsigned RW = 4;  // remaining / length counter width

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        base_q, base_d;
  logic [IT_MAX-1:0] mask_q, mask_d;
  logic [CW-1:0]     owner_q, owner_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [RW-1:0]     len_q, len_d;

  logic [FW-1:0]     flags_q [NUM_CTX];

  logic [FW-1:0]     cur_flags;
  logic [RW-1:0]     slot;
  logic              slot_else;
  logic              len_ok;
  logic              owner_hit;
  logic              open_blk;
  logic              err;
  logic [3:0]        eff_cond;
  logic              cond_pass;
  logic              wr_nz;
  logic              wr_cv;

  // Flag set of the selected context; out-of-range selects read as zero
  always_comb begin
    cur_flags = '0;
    for (int unsigned c = 0; c < NUM_CTX; c++) begin
      if (32'(ctx_sel) == c) cur_flags = flags_q[c];
    end
  end

  // Else bit for the current block slot (slot = captured length - remaining)
  always_comb begin
    slot      = len_q - rem_q;
    slot_else = 1'b0;
    for (int unsigned i = 0; i < IT_MAX; i++) begin
      if (RW'(i) == slot) slot_else = mask_q[i];
    end
  end

  assign len_ok    = (it_len != '0) && (32'(it_len) <= IT_MAX);
  assign owner_hit = (ctx_sel == owner_q);

  // Next-state logic and effective-condition selection
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    mask_d   = mask_q;
    owner_d  = owner_q;
    rem_d    = rem_q;
    len_d    = len_q;
    eff_cond = cond;
    open_blk = 1'b0;
    err      = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid && it_start) begin
          if (len_ok) begin
            open_blk = 1'b1;
            state_d  = ACTIVE;
            base_d   = cond;
            mask_d   = it_mask;
            owner_d  = ctx_sel;
            rem_d    = it_len;
            len_d    = it_len;
          end else begin
            err = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (instr_valid && owner_hit) begin
          // Else slots flip the condition sense via bit 0
          eff_cond = {base_q[3:1], base_q[0] ^ slot_else};
          rem_d    = rem_q - RW'(1);
          if (rem_q == RW'(1)) state_d = IDLE;
          if (it_start) err = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ARM condition decode against the pre-edge flags {Z,N,C,V}
  always_comb begin
    logic z, n, c, v;
    {z, n, c, v} = cur_flags;
    cond_pass    = 1'b0;
    case (eff_cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = ~c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = c & ~z;
      4'b1001: cond_pass = ~(c & ~z);
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = ~z & (n == v);
      4'b1101: cond_pass = ~(~z & (n == v));
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // The block-opening instruction always executes but never writes flags
  assign exec  = instr_valid & (open_blk | cond_pass);
  assign wr_nz = instr_valid & cond_pass & ~open_blk & flag_write[1];
  assign wr_cv = instr_valid & cond_pass & ~open_blk & flag_write[0];

  assign flags_out    = cur_flags;
  assign it_active    = (state_q == ACTIVE);
  assign it_remaining = (state_q == ACTIVE) ? rem_q : '0;
  assign it_error     = err & ~reset;

  // FSM and captured block context
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      mask_q  <= '0;
      owner_q <= '0;
      rem_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      mask_q  <= mask_d;
      owner_q <= owner_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
    end
  end

  // Per-context flag storage; N,Z and C,V pairs are written independently
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < NUM_CTX; c++) flags_q[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CTX; c++) begin
        if (32'(ctx_sel) == c) begin
          if (wr_nz) flags_q[c][3:2] <= alu_flags[3:2];
          if (wr_cv) flags_q[c][1:0] <= alu_flags[1:0];
        end
      end
    end
  end

endmodule

// File: doc/cond_exec_unit.md
COND_EXEC_UNIT -- requirements
Module: cond_exec_unit

Interface
REQ-001 The block SHALL have parameter NUM_CTX, default 2, giving the number of independent flag contexts (minimum 1).
REQ-002 The block SHALL have parameter IT_MAX, default 4, giving the maximum predicated-block length (1..8).
REQ-003 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-004 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port instr_valid  input  1  an instruction is presented this cycle.
REQ-007 Port ctx_sel  input  max(1,$clog2(NUM_CTX))  flag context used by the presented instruction.
REQ-008 Port cond  input  4  ARM condition field, instr[31:28].
REQ-009 Port alu_flags  input  4  new flags from the ALU, ordered {Z,N,C,V} (bit 3 = Z).
REQ-010 Port flag_write  input  2  bit 1 updates N,Z; bit 0 updates C,V.
REQ-011 Port it_start  input  1  the presented instruction opens a predicated block.
REQ-012 Port it_len  input  4  number of instructions in the block.
REQ-013 Port it_mask  input  IT_MAX  per-slot else bit; bit k applies to slot k.
REQ-014 Port exec  output  1  the presented instruction executes.
REQ-015 Port flags_out  output  4  stored {Z,N,C,V} of context ctx_sel.
REQ-016 Port it_active  output  1  predicated block in progress.
REQ-017 Port it_remaining  output  4  slots left in the current block.
REQ-018 Port it_error  output  1  one-cycle pulse on a rejected it_start.

Function
REQ-019 exec SHALL be combinational from the effective condition and the stored flags of context ctx_sel, and SHALL be 0 when instr_valid=0.
REQ-020 Conditions SHALL decode as: 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V; 1000 C&~Z; 1001 ~(C&~Z); 1010 N==V; 1011 N!=V; 1100 ~Z&(N==V); 1101 ~(~Z&(N==V)); 1110 1; 1111 0. No X is output for any condition value.
REQ-021 On a clock edge with instr_valid & exec, flag_write[1] SHALL load N,Z and flag_write[0] SHALL load C,V of context ctx_sel from alu_flags. Other contexts and unselected flag pairs SHALL hold.
REQ-022 exec SHALL use the pre-edge flags. A flag write by one instruction SHALL become visible to the next cycle's instruction, with no bypass.
REQ-023 The FSM SHALL have two states, IDLE and ACTIVE. It SHALL hold base condition, mask, owning context and a remaining counter.
REQ-024 In IDLE, instr_valid & it_start with 1 <= it_len <= IT_MAX SHALL capture base=cond, mask=it_mask, owner=ctx_sel, remaining=it_len, and move to ACTIVE.
REQ-025 The opening instruction SHALL have exec=1 and SHALL NOT write flags, regardless of cond or flag_write.
REQ-026 In IDLE, it_start with it_len=0 or it_len>IT_MAX SHALL pulse it_error, leave the FSM in IDLE, and treat the instruction as a normal conditional instruction.
REQ-027 In ACTIVE, a valid instruction with ctx_sel=owner SHALL use slot k = it_len_captured - remaining.
REQ-028 For that slot, the effective condition SHALL be base if mask[k]=0, else base with bit 0 inverted. The input cond SHALL be ignored.
REQ-029 The same owner-context instruction SHALL decrement remaining. The FSM SHALL return to IDLE on the edge where remaining goes from 1 to 0.
REQ-030 In ACTIVE, instructions with ctx_sel!=owner SHALL evaluate their own cond normally and SHALL NOT decrement the counter.
REQ-031 In ACTIVE, it_start from the owner context SHALL pulse it_error and consume its slot as a normal predicated instruction; the block SHALL NOT restart.
REQ-032 Cycles with instr_valid=0 SHALL change no state.
REQ-033 it_active SHALL equal (state==ACTIVE). it_remaining SHALL be 0 in IDLE.

Reset
REQ-034 reset SHALL take priority over all inputs.
REQ-035 On reset, all context flags SHALL clear to 0000, the FSM SHALL go to IDLE, and remaining, base, mask and owner SHALL clear to 0.
REQ-036 During reset, it_error SHALL be 0.
REQ-037 Reset asserted mid-block SHALL abort the block; the first post-reset instruction SHALL be evaluated unpredicated.

Verification
REQ-038 After reset, cond=0000, instr_valid=1 -> exec=0. Then cond=0001 -> exec=1. Then cond=1111 -> exec=0.
REQ-039 Context 0: cond=1110, flag_write=10, alu_flags=1000 -> next cycle flags_out=1000 and context 1 flags_out=0000. Then flag_write=01, alu_flags=0011 -> flags_out=1011.
REQ-040 Context 0 flags Z=1, it_start with cond=0000, it_len=3, it_mask=010 -> following exec sequence 1,0,1, it_remaining 3,2,1,0, it_active drops after the third instruction.
REQ-041 Block owned by context 0 with a context-1 instruction interleaved -> the context-1 instruction uses its own cond and it_remaining is unchanged.
REQ-042 it_start with it_len=5 (IT_MAX=4) -> it_error=1 for one cycle and it_active=0. Nested it_start inside a block -> it_error=1 and it_remaining decrements.
REQ-043 Reset asserted with it_remaining=2 -> it_active=0, it_remaining=0, flags 0000 on the next cycle.
